fleet_state: RTL and testbench

- Successor to the single-plane state updater. It holds the kinematic state of NUM_PLANES aircraft in register arrays.
- On each frame tick it updates every FLYING plane in index order (0..NUM_PLANES-1) through one shared, time-multiplexed fixed-point datapath.
- Adds features the single-plane updater lacks: parametrised Q format, saturating arithmetic, stall handling, modular angle wrap, per-plane input/velocity handshakes with index, an indexed readout port and overrun counting.
- Sits between the input controller / velocity converter and the renderer.

---
 rtl/fleet_state_if.sv | 58 +++++
 rtl/fleet_state.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_fleet_state.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fleet_state_if.sv
// Bus between fleet_state and its neighbours: the frame strobe, the
// per-plane input and velocity handshakes, and the indexed readout port.
//
// Handshake: req_input / req_vel are one-cycle requests with the plane
// index on input_idx. The source answers by raising input_ready / vel_ready
// while its data is valid; the updater waits for ready and captures the
// data on the clock edge where it sees ready high. Ready may be tied high.
interface fleet_state_if #(
  parameter int NUM_PLANES  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int INPUT_WIDTH = 8
);
  localparam int IDXW = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1;

  logic                          tick;
  logic                          update_enable;
  logic                          busy;
  logic                          frame_done;
  logic                          req_input;
  logic [IDXW-1:0]               input_idx;
  logic                          input_ready;
  logic signed [INPUT_WIDTH-1:0] pitch_change;
  logic signed [INPUT_WIDTH-1:0] roll_change;
  logic [INPUT_WIDTH-1:0]        throttle;
  logic                          req_vel;
  logic                          vel_ready;
  logic signed [DATA_WIDTH-1:0]  v_x;
  logic signed [DATA_WIDTH-1:0]  v_y;
  logic signed [DATA_WIDTH-1:0]  v_z;
  logic [IDXW-1:0]               rd_idx;
  logic [DATA_WIDTH-1:0]         rd_x;
  logic [DATA_WIDTH-1:0]         rd_y;
  logic [DATA_WIDTH-1:0]         rd_z;
  logic [DATA_WIDTH-1:0]         rd_speed;
  logic [DATA_WIDTH-1:0]         rd_pitch;
  logic [DATA_WIDTH-1:0]         rd_roll;
  logic [DATA_WIDTH-1:0]         rd_heading;
  logic [2:0]                    rd_status;
  logic [4:0]                    flying_count;
  logic [7:0]                    overrun_count;
  logic [3:0]                    dbg_state;

  modport master (
    output tick, update_enable, input_ready, pitch_change, roll_change,
           throttle, vel_ready, v_x, v_y, v_z, rd_idx,
    input  busy, frame_done, req_input, input_idx, req_vel, rd_x, rd_y,
           rd_z, rd_speed, rd_pitch, rd_roll, rd_heading, rd_status,
           flying_count, overrun_count, dbg_state
  );

  modport slave (
    input  tick, update_enable, input_ready, pitch_change, roll_change,
           throttle, vel_ready, v_x, v_y, v_z, rd_idx,
    output busy, frame_done, req_input, input_idx, req_vel, rd_x, rd_y,
           rd_z, rd_speed, rd_pitch, rd_roll, rd_heading, rd_status,
           flying_count, overrun_count, dbg_state
  );
endinterface

// File: rtl/fleet_state.sv
// Kinematic state of NUM_PLANES aircraft. Each frame tick walks the FLYING
// planes in index order through one shared fixed-point datapath.
module fleet_state #(
  parameter int NUM_PLANES  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int FRAC_BITS   = 16,
  parameter int INPUT_WIDTH = 8,
  parameter logic signed [DATA_WIDTH-1:0] UPDATE_S        = 32'h0000_199A,
  parameter logic signed [DATA_WIDTH-1:0] INITIAL_X       = '0,
  parameter logic signed [DATA_WIDTH-1:0] SPACING_X       = 32'h000A_0000,
  parameter logic signed [DATA_WIDTH-1:0] INITIAL_Y       = 32'h0064_0000,
  parameter logic signed [DATA_WIDTH-1:0] INITIAL_SPEED   = 32'h0014_0000,
  parameter logic signed [DATA_WIDTH-1:0] STALL_SPEED     = 32'h0005_0000,
  parameter logic signed [DATA_WIDTH-1:0] DRAG_COEF       = 32'h0005_0000,
  parameter logic signed [DATA_WIDTH-1:0] THRUST_COEF     = 32'h0064_0000,
  parameter logic signed [DATA_WIDTH-1:0] MASS_INV        = 32'h0000_028F,
  parameter logic signed [DATA_WIDTH-1:0] ROLL_TO_HEADING = 32'h0001_0000,
  parameter logic signed [DATA_WIDTH-1:0] GROUND_Y        = 32'h0002_0000,
  parameter logic signed [DATA_WIDTH-1:0] LAND_SPEED_MAX  = 32'h000A_0000
) (
  input logic         clk,
  input logic         reset,
  fleet_state_if.slave bus
);

  localparam int IDXW = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_PLANES - 1);

  localparam logic signed [DATA_WIDTH-1:0] Q_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] Q_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] DEG90  = DATA_WIDTH'(90) << FRAC_BITS;
  localparam logic signed [DATA_WIDTH-1:0] DEG180 = DATA_WIDTH'(180) << FRAC_BITS;
  localparam logic signed [DATA_WIDTH-1:0] DEG360 = DATA_WIDTH'(360) << FRAC_BITS;
  localparam logic signed [DATA_WIDTH-1:0] NEG180 = -DEG180;
  localparam logic signed [DATA_WIDTH-1:0] STALL_PITCH = -DEG90;
  localparam logic signed [DATA_WIDTH-1:0] TEN_Q  = DATA_WIDTH'(10) << FRAC_BITS;

  localparam logic [2:0] ST_FLYING  = 3'b001;
  localparam logic [2:0] ST_LANDED  = 3'b010;
  localparam logic [2:0] ST_CRASHED = 3'b100;

  typedef enum logic [3:0] {
    S_IDLE, S_SELECT, S_POLL_INPUT, S_WAIT_INPUT, S_UPDATE_SPRH,
    S_WRAP_ANGLES, S_POLL_VEL, S_WAIT_VEL, S_UPDATE_XYZ, S_UPDATE_STATUS,
    S_DONE
  } state_t;

  // Full-width signed product, keeping bits [FRAC_BITS +: DATA_WIDTH]
  // (arithmetic shift, so truncation is toward minus infinity).
  function automatic logic signed [DATA_WIDTH-1:0] qmul(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [2*DATA_WIDTH-1:0] p;
    p = a * b;
    return DATA_WIDTH'(p >>> FRAC_BITS);
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat_add(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) return s[DATA_WIDTH] ? Q_MIN : Q_MAX;
    return s[DATA_WIDTH-1:0];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat_sub(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) return s[DATA_WIDTH] ? Q_MIN : Q_MAX;
    return s[DATA_WIDTH-1:0];
  endfunction

  // One correction is enough: no angle moves by 180 degrees in a frame.
  function automatic logic signed [DATA_WIDTH-1:0] wrap_pm180(
    input logic signed [DATA_WIDTH-1:0] a
  );
    if (a >= DEG180) return a - DEG360;
    if (a < NEG180) return a + DEG360;
    return a;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] wrap_360(
    input logic signed [DATA_WIDTH-1:0] a
  );
    if (a >= DEG360) return a - DEG360;
    if (a < 0) return a + DEG360;
    return a;
  endfunction

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [7:0]      overrun_q;

  logic signed [DATA_WIDTH-1:0] x_q [NUM_PLANES];
  logic signed [DATA_WIDTH-1:0] y_q [NUM_PLANES];
  logic signed [DATA_WIDTH-1:0] z_q [NUM_PLANES];
  logic signed [DATA_WIDTH-1:0] speed_q [NUM_PLANES];
  logic signed [DATA_WIDTH-1:0] pitch_q [NUM_PLANES];
  logic signed [DATA_WIDTH-1:0] roll_q [NUM_PLANES];
  logic signed [DATA_WIDTH-1:0] heading_q [NUM_PLANES];
  logic [2:0]                   status_q [NUM_PLANES];

  logic signed [INPUT_WIDTH-1:0] pc_q, rc_q;
  logic [INPUT_WIDTH-1:0]        thr_q;
  logic signed [DATA_WIDTH-1:0]  vx_q, vy_q, vz_q;

  logic signed [DATA_WIDTH-1:0] cur_spd, cur_pitch, cur_roll, cur_hdg, cur_y;
  logic signed [DATA_WIDTH-1:0] thr_fix, pc_fix, rc_fix, sq, thrust, drag, net, accel;
  logic signed [DATA_WIDTH-1:0] speed_n, pitch_n, roll_n, heading_n;
  logic signed [DATA_WIDTH-1:0] x_n, y_n, z_n;

  assign cur_spd   = speed_q[idx_q];
  assign cur_pitch = pitch_q[idx_q];
  assign cur_roll  = roll_q[idx_q];
  assign cur_hdg   = heading_q[idx_q];
  assign cur_y     = y_q[idx_q];

  // FSM state and plane index registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: walk the planes, skipping those no longer flying.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.tick && bus.update_enable) begin
          idx_d   = '0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (status_q[idx_q] == ST_FLYING) begin
          state_d = S_POLL_INPUT;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_POLL_INPUT:  state_d = S_WAIT_INPUT;
      S_WAIT_INPUT:  if (bus.input_ready) state_d = S_UPDATE_SPRH;
      S_UPDATE_SPRH: state_d = S_WRAP_ANGLES;
      S_WRAP_ANGLES: state_d = S_POLL_VEL;
      S_POLL_VEL:    state_d = S_WAIT_VEL;
      S_WAIT_VEL:    if (bus.vel_ready) state_d = S_UPDATE_XYZ;
      S_UPDATE_XYZ:  state_d = S_UPDATE_STATUS;
      S_UPDATE_STATUS: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          state_d = S_SELECT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = (state_q == S_DONE);
  assign bus.req_input  = (state_q == S_POLL_INPUT);
  assign bus.req_vel    = (state_q == S_POLL_VEL);
  assign bus.input_idx  = idx_q;
  assign bus.dbg_state  = state_q;
  assign bus.overrun_count = overrun_q;

  // Capture controller inputs and velocities on the edge their ready is seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= '0;
      rc_q  <= '0;
      thr_q <= '0;
      vx_q  <= '0;
      vy_q  <= '0;
      vz_q  <= '0;
    end else begin
      if (state_q == S_WAIT_INPUT && bus.input_ready) begin
        pc_q  <= bus.pitch_change;
        rc_q  <= bus.roll_change;
        thr_q <= bus.throttle;
      end
      if (state_q == S_WAIT_VEL && bus.vel_ready) begin
        vx_q <= bus.v_x;
        vy_q <= bus.v_y;
        vz_q <= bus.v_z;
      end
    end
  end

  // Shared datapath for the plane selected by idx_q.
  always_comb begin
    thr_fix = DATA_WIDTH'(thr_q) << FRAC_BITS;
    pc_fix  = DATA_WIDTH'(pc_q) << FRAC_BITS;
    rc_fix  = DATA_WIDTH'(rc_q) << FRAC_BITS;
    sq      = qmul(cur_spd, cur_spd);
    thrust  = qmul(THRUST_COEF, thr_fix);
    drag    = qmul(DRAG_COEF, sq);
    net     = sat_sub(thrust, drag);
    accel   = qmul(qmul(net, MASS_INV), UPDATE_S);
    if (cur_spd < STALL_SPEED) begin
      speed_n = sat_add(cur_spd, qmul(TEN_Q, UPDATE_S));
      pitch_n = STALL_PITCH;
    end else begin
      speed_n = sat_add(cur_spd, accel);
      pitch_n = sat_add(cur_pitch, qmul(pc_fix, UPDATE_S));
    end
    if (speed_n < 0) speed_n = '0;
    roll_n    = sat_add(cur_roll, qmul(rc_fix, UPDATE_S));
    heading_n = sat_add(cur_hdg, qmul(qmul(cur_roll, ROLL_TO_HEADING), UPDATE_S));
    x_n = sat_add(x_q[idx_q], qmul(vx_q, UPDATE_S));
    y_n = sat_add(cur_y, qmul(vy_q, UPDATE_S));
    z_n = sat_add(z_q[idx_q], qmul(vz_q, UPDATE_S));
  end

  // Per-plane state: one field group committed per FSM step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PLANES; i++) begin
        x_q[i]       <= INITIAL_X + DATA_WIDTH'(i) * SPACING_X;
        y_q[i]       <= INITIAL_Y;
        z_q[i]       <= '0;
        speed_q[i]   <= INITIAL_SPEED;
        pitch_q[i]   <= '0;
        roll_q[i]    <= '0;
        heading_q[i] <= '0;
        status_q[i]  <= ST_FLYING;
      end
    end else begin
      case (state_q)
        S_UPDATE_SPRH: begin
          speed_q[idx_q]   <= speed_n;
          pitch_q[idx_q]   <= pitch_n;
          roll_q[idx_q]    <= roll_n;
          heading_q[idx_q] <= heading_n;
        end
        S_WRAP_ANGLES: begin
          pitch_q[idx_q]   <= wrap_pm180(cur_pitch);
          roll_q[idx_q]    <= wrap_pm180(cur_roll);
          heading_q[idx_q] <= wrap_360(cur_hdg);
        end
        S_UPDATE_XYZ: begin
          x_q[idx_q] <= x_n;
          y_q[idx_q] <= y_n;
          z_q[idx_q] <= z_n;
        end
        S_UPDATE_STATUS: begin
          if (cur_y < GROUND_Y) begin
            status_q[idx_q] <= (cur_spd > LAND_SPEED_MAX) ? ST_CRASHED : ST_LANDED;
          end
        end
        default: ;
      endcase
    end
  end

  // Ticks arriving mid-frame are dropped and counted, saturating at 255.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= '0;
    end else if (bus.tick && state_q != S_IDLE && overrun_q != 8'hFF) begin
      overrun_q <= overrun_q + 8'd1;
    end
  end

  // Combinational readout; unknown indices read as zero.
  always_comb begin
    bus.rd_x       = '0;
    bus.rd_y       = '0;
    bus.rd_z       = '0;
    bus.rd_speed   = '0;
    bus.rd_pitch   = '0;
    bus.rd_roll    = '0;
    bus.rd_heading = '0;
    bus.rd_status  = '0;
    for (int i = 0; i < NUM_PLANES; i++) begin
      if (bus.rd_idx == IDXW'(i)) begin
        bus.rd_x       = x_q[i];
        bus.rd_y       = y_q[i];
        bus.rd_z       = z_q[i];
        bus.rd_speed   = speed_q[i];
        bus.rd_pitch   = pitch_q[i];
        bus.rd_roll    = roll_q[i];
        bus.rd_heading = heading_q[i];
        bus.rd_status  = status_q[i];
      end
    end
  end

  // Number of planes still flying.
  always_comb begin
    bus.flying_count = '0;
    for (int i = 0; i < NUM_PLANES; i++) begin
      bus.flying_count = bus.flying_count + {4'b0, status_q[i][0]};
    end
  end

endmodule

// File: tb/tb_fleet_state.sv
// Directed bench for fleet_state: reset values, frame timing and request
// order, Q arithmetic, stall, angle wrap, crash/skip, overrun and async reset.
module tb_fleet_state;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int IW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;

  fleet_state_if #(.NUM_PLANES(NP), .DATA_WIDTH(DW), .INPUT_WIDTH(IW)) bus ();
  fleet_state_if #(.NUM_PLANES(NP), .DATA_WIDTH(DW), .INPUT_WIDTH(IW)) bus_slow ();

  fleet_state #(.NUM_PLANES(NP), .DATA_WIDTH(DW), .INPUT_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  fleet_state #(.NUM_PLANES(NP), .DATA_WIDTH(DW), .INPUT_WIDTH(IW),
                .INITIAL_SPEED(32'h0004_0000)) dut_slow (
    .clk(clk), .reset(reset), .bus(bus_slow)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Per-plane vertical velocity: plane 1 can be given its own value.
  logic signed [DW-1:0] vy_all, vy_p1;
  assign bus.v_y = (bus.input_idx == 2'd1) ? vy_p1 : vy_all;

  // The slow-start instance sees exactly the same stimulus.
  assign bus_slow.tick          = bus.tick;
  assign bus_slow.update_enable = bus.update_enable;
  assign bus_slow.input_ready   = bus.input_ready;
  assign bus_slow.pitch_change  = bus.pitch_change;
  assign bus_slow.roll_change   = bus.roll_change;
  assign bus_slow.throttle      = bus.throttle;
  assign bus_slow.vel_ready     = bus.vel_ready;
  assign bus_slow.v_x           = bus.v_x;
  assign bus_slow.v_y           = bus.v_y;
  assign bus_slow.v_z           = bus.v_z;
  assign bus_slow.rd_idx        = bus.rd_idx;

  // ---------------- scoreboard ----------------
  int n_compared = 0;
  int n_mismatched = 0;
  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Raise tick for one cycle; count edges until frame_done is seen and log
  // every req_input index. Bounded so a stuck FSM cannot hang the run.
  task automatic run_frame(output int cycles);
    bit done;
    got_q.delete();
    @(negedge clk);
    bus.tick = 1'b1;
    cycles = 0;
    done = 1'b0;
    while (!done && cycles < 200) begin
      @(posedge clk);
      #1;
      bus.tick = 1'b0;
      cycles++;
      if (bus.req_input) got_q.push_back(bus.input_idx);
      if (bus.frame_done) done = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_req_order(input string tag);
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check_eq({tag, "_idx"}, got_q[i], exp_q[i]);
    end
    exp_q.delete();
  endtask

  task automatic select_plane(input int i);
    bus.rd_idx = 2'(i);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cycles;
    logic signed [31:0] exp_p;

    bus.tick = 1'b0;
    bus.update_enable = 1'b1;
    bus.input_ready = 1'b1;
    bus.vel_ready = 1'b1;
    bus.pitch_change = '0;
    bus.roll_change = '0;
    bus.throttle = '0;
    bus.v_x = '0;
    bus.v_z = '0;
    bus.rd_idx = '0;
    vy_all = '0;
    vy_p1 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset state.
    select_plane(2);
    check_eq("rst_x2", bus.rd_x, 32'h0014_0000);
    check_eq("rst_y2", bus.rd_y, 32'h0064_0000);
    check_eq("rst_speed2", bus.rd_speed, 32'h0014_0000);
    check_eq("rst_status2", bus.rd_status, 32'd1);
    check_eq("rst_busy", bus.busy, 32'd0);
    check_eq("rst_flying", bus.flying_count, 32'd4);
    check_eq("rst_overrun", bus.overrun_count, 32'd0);

    // Tick is ignored while update_enable is low.
    bus.update_enable = 1'b0;
    @(negedge clk);
    bus.tick = 1'b1;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
    check_eq("gated_busy", bus.busy, 32'd0);
    check_eq("gated_overrun", bus.overrun_count, 32'd0);
    bus.update_enable = 1'b1;

    // One frame: pitch_change=10, throttle=0, v_x=10.
    bus.pitch_change = 8'sd10;
    bus.v_x = 32'h000A_0000;
    for (int i = 0; i < NP; i++) exp_q.push_back(2'(i));
    run_frame(cycles);
    check_eq("frame_len4", cycles, 32'd37);
    check_req_order("req4");
    for (int i = 0; i < NP; i++) begin
      select_plane(i);
      check_eq("pitch_f1", bus.rd_pitch, 32'h0001_0004);
      check_eq("x_f1", bus.rd_x, 32'(i) * 32'h000A_0000 + 32'h0001_0004);
      check_eq("y_f1", bus.rd_y, 32'h0064_0000);
      check_eq("speed_drag_f1", bus.rd_speed, 32'h0012_0040);
      check_eq("stall_pitch", bus_slow.rd_pitch, 32'hFFA6_0000);
      check_eq("stall_speed", bus_slow.rd_speed, 32'h0005_0004);
    end

    // Pitch wrap: 127 deg/s for 15 frames, throttle balancing drag at 20.
    apply_reset();
    bus.pitch_change = 8'sd127;
    bus.throttle = 8'd20;
    bus.v_x = '0;
    exp_p = '0;
    for (int f = 0; f < 15; f++) begin
      run_frame(cycles);
      exp_p = exp_p + 32'sd832358;
      if (exp_p >= 32'sh00B4_0000) exp_p = exp_p - 32'sh0168_0000;
      select_plane(0);
      check_eq("pitch_wrap", bus.rd_pitch, exp_p);
      check_eq("pitch_range", ($signed(bus.rd_pitch) >= 32'shFF4C_0000 &&
                               $signed(bus.rd_pitch) < 32'sh00B4_0000), 32'd1);
    end
    check_eq("pitch_f15", bus.rd_pitch, 32'hFF56_82FA);
    check_eq("speed_balanced", bus.rd_speed, 32'h0014_0000);
    check_eq("heading_still", bus.rd_heading, 32'd0);

    // Plane 1 dives into the ground at speed.
    apply_reset();
    bus.pitch_change = '0;
    bus.throttle = 8'd20;
    vy_p1 = 32'hFC18_0000;
    run_frame(cycles);
    check_eq("frame_len_crash", cycles, 32'd37);
    select_plane(1);
    check_eq("crash_status", bus.rd_status, 32'b100);
    check_eq("crash_y", bus.rd_y, 32'hFFFF_FE70);
    select_plane(0);
    check_eq("p0_status", bus.rd_status, 32'b001);
    check_eq("flying_after_crash", bus.flying_count, 32'd3);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    run_frame(cycles);
    check_eq("frame_len_skip", cycles, 32'd29);
    check_req_order("req_skip");
    select_plane(1);
    check_eq("crash_y_frozen", bus.rd_y, 32'hFFFF_FE70);
    vy_p1 = '0;

    // Overrun and mid-frame asynchronous reset.
    apply_reset();
    bus.pitch_change = 8'sd10;
    bus.v_x = 32'h000A_0000;
    @(negedge clk);
    bus.tick = 1'b1;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.tick = 1'b1;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
    check_eq("overrun_busy", bus.busy, 32'd1);
    check_eq("overrun_count", bus.overrun_count, 32'd1);
    repeat (2) @(posedge clk);
    select_plane(0);
    check_eq("pre_reset_pitch", bus.rd_pitch, 32'h0001_0004);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("areset_busy", bus.busy, 32'd0);
    check_eq("areset_done", bus.frame_done, 32'd0);
    check_eq("areset_overrun", bus.overrun_count, 32'd0);
    check_eq("areset_pitch", bus.rd_pitch, 32'd0);
    check_eq("areset_x", bus.rd_x, 32'd0);
    check_eq("areset_speed", bus.rd_speed, 32'h0014_0000);
    check_eq("areset_flying", bus.flying_count, 32'd4);
    @(negedge clk);
    reset = 1'b1;

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
